mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 8:1 mux datapath among 8 requesters.
- Drives the mux `sel` input. Produces a one-hot grant and a valid flag for the downstream consumer.
- Ownership is locked: the current owner keeps the mux until it drops its request.
- With the optional timeout compiled in, the owner is also preempted after MAX_HOLD cycles.

Parameters:
- MAX_HOLD, 16, max consecutive cycles one owner may hold the mux when others are waiting. Legal range 2..255. Used only with MUX_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge
- req  input  8  request vector; bit i = requester i (maps to mux input a..h for i=0..7); held high while the requester wants or owns the mux
- grant  output  8  registered one-hot grant; all zero when idle
- sel  output  3  registered binary index of the owner; connects to mux sel
- valid  output  1  registered; 1 when grant is non-zero (sel is meaningful)
- switch  output  1  registered 1-cycle pulse on every cycle where grant takes a new non-zero value

Behaviour:
- Reset (rst_n=0 at an edge):
  - grant=0, sel=0, valid=0, switch=0.
  - State IDLE, hold counter=0.
  - Round-robin pointer last=7, so the first search starts at index 0.
  - Reset mid-grant takes effect at that edge regardless of req.
- Winner search: the first set bit of the candidate vector, scanning upward from (last+1) mod 8 with wrap-around.
- States: IDLE and OWN. Owner index o = sel while in OWN.
- IDLE:
  - req==0: stay in IDLE; outputs unchanged (grant=0, valid=0, sel holds its last value).
  - req!=0: next edge → OWN with winner w. grant=1<<w, sel=w, valid=1, switch=1, counter=0.
  - Latency is 1 clock from req sampled to grant visible.
- OWN, req[o]==1, no preemption:
  - Outputs held. switch=0.
  - Counter increments, saturating at MAX_HOLD-1.
- OWN, req[o]==0 (release):
  - Set last=o.
  - If (req & ~(1<<o))!=0: next edge grants the next winner directly, with no idle bubble. switch=1, counter=0.
  - Else: next edge → IDLE. grant=0, valid=0, switch=0, sel keeps o.
- Other-requester changes: req bits of non-owners may toggle freely and never affect the current owner, except through preemption.
- No request of a non-owner is ever lost. A requester that stays high is granted within 7 ownership periods.
- At most one grant bit is ever set. sel always equals the encoded grant whenever valid=1.
- Single requester that drops and later reasserts: OWN → IDLE → OWN. Round-robin order is still honoured via last.

Optional Feature:
- MUX_ARB_TIMEOUT_EN defined:
  - In OWN with req[o]==1, counter==MAX_HOLD-1 and (req & ~(1<<o))!=0 → preempt.
  - Preempt means: last=o, next edge grants the next winner from the other requesters, switch=1, counter=0.
  - If no other requester is waiting, the owner keeps the mux and the counter stays saturated.
  - Preemption and release in the same cycle behave as a release.
- MUX_ARB_TIMEOUT_EN undefined:
  - No preemption; the owner holds indefinitely while req[o]=1.
  - The counter may be removed, and MAX_HOLD is ignored.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 clocks with req=8'hFF → grant=0, sel=0, valid=0, switch=0. Release rst_n, req=0 for 3 clocks → outputs unchanged.
- Single request: req=8'h10 → one clock later grant=8'h10, sel=4, valid=1, switch=1 for one cycle. Drop req → next clock grant=0, valid=0, sel stays 4.
- Round-robin release chain: req=8'hFF after reset. Each owner drops its bit one cycle after being granted → grant sequence 01,02,04,...,80 with switch=1 each time and no idle cycles between owners.
- Wrap/pointer:
  - Grant index 6, then req=8'h41 with bit 6 dropped → next grant=8'h01 (wraps past 7).
  - Then req=8'h81 with bit 0 dropped → grant=8'h80.
- Simultaneous events: owner 2 drops in the same cycle that bits 1 and 5 rise → grant=8'h20 (search starts at 3), never 8'h02. Verify one-hot every cycle.
- Timeout (MUX_ARB_TIMEOUT_EN, MAX_HOLD=4):
  - req=8'h03 held constant → owner 0 for 4 cycles, then owner 1 for 4, then back to 0, with switch pulses at each handoff.
  - With req=8'h01 only → owner 0 is never preempted.
  - Without the macro, req=8'h03 gives grant stuck at 8'h01.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter driving the sel input of an 8:1 mux.
// Define MUX_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles while others wait.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid,
    output logic       switch
);

    localparam int unsigned N  = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [SW-1:0]  last_q, last_d;
    logic           valid_q, valid_d;
    logic           switch_q, switch_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   others_c;
    logic [SW-1:0]  pick_req_c;
    logic [SW-1:0]  pick_oth_c;
    logic           preempt_c;

    // First set bit of cand scanning upward from base+1 with wrap-around.
    function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] cand, input logic [SW-1:0] base);
        logic [SW-1:0] idx;
        logic [SW-1:0] pick;
        logic          found;
        pick  = base;
        found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = base + SW'(i);
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign others_c   = req & ~(N'(1) << sel_q);
    assign pick_req_c = rr_pick(req, last_q);
    assign pick_oth_c = rr_pick(others_c, sel_q);

`ifdef MUX_ARB_TIMEOUT_EN
    assign preempt_c = (cnt_q == CNT_MAX) && (others_c != '0);
`else
    assign preempt_c = 1'b0;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        last_d   = last_q;
        valid_d  = valid_q;
        switch_d = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d  = OWN;
                    grant_d  = N'(1) << pick_req_c;
                    sel_d    = pick_req_c;
                    valid_d  = 1'b1;
                    switch_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            OWN: begin
                if (!req[sel_q] || preempt_c) begin
                    // Release or preemption: hand over directly when anyone else waits.
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (others_c != '0) begin
                        grant_d  = N'(1) << pick_oth_c;
                        sel_d    = pick_oth_c;
                        switch_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            last_q   <= SW'(N - 1);
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign valid  = valid_q;
    assign switch = switch_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, timeout sequence, random vs model.
module tb_mux_rr_arbiter;

    localparam int unsigned MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       switch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .grant  (grant),
        .sel    (sel),
        .valid  (valid),
        .switch (switch)
    );

    typedef struct {
        logic       rst;
        logic [7:0] rq;
        logic [7:0] g;
        logic [2:0] s;
        logic       v;
        logic       sw;
    } vec_t;

    vec_t tbl[$];

    // Reference model: owner as integer index (-1 = nobody), pointer and hold count as ints.
    int m_owner;
    int m_sel;
    int m_last;
    int m_hold;
    int m_sw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input logic [7:0] c, input int from_last);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (from_last + k) % 8;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [7:0] r);
        logic [7:0] oth;
        if (!rst) begin
            m_owner = -1; m_sel = 0; m_last = 7; m_hold = 0; m_sw = 0;
        end else if (m_owner < 0) begin
            m_sw = 0;
            if (r != 8'h00) begin
                m_owner = m_pick(r, m_last);
                m_sel = m_owner; m_sw = 1; m_hold = 0;
            end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (!r[m_owner] || (TIMEOUT && m_hold == int'(MAX_HOLD) - 1 && oth != 8'h00)) begin
                m_last = m_owner;
                m_hold = 0;
                if (oth != 8'h00) begin
                    m_owner = m_pick(oth, m_last);
                    m_sel = m_owner; m_sw = 1;
                end else begin
                    m_owner = -1; m_sw = 0;
                end
            end else begin
                m_sw = 0;
                if (m_hold < int'(MAX_HOLD) - 1) m_hold++;
            end
        end
    endtask

    // Drive one cycle at the falling edge, then let outputs settle after the rising edge.
    task automatic cyc(input logic rst, input logic [7:0] r);
        @(negedge clk);
        rst_n = rst;
        req   = r;
        @(posedge clk);
        #1;
        model_step(rst, r);
    endtask

    function automatic void add(input logic rst, input logic [7:0] rq, input logic [7:0] g,
                                input logic [2:0] s, input logic v, input logic sw);
        vec_t e;
        e.rst = rst; e.rq = rq; e.g = g; e.s = s; e.v = v; e.sw = sw;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [7:0] r;
        logic [7:0] exp_g;
        int         exp_o;
        logic       exp_sw;

        rst_n = 1'b0;
        req   = 8'h00;

        // Reset, idle, single request, release chain, wrap, simultaneous drop/rise.
        add(0, 8'hFF, 8'h00, 3'd0, 0, 0);
        add(0, 8'hFF, 8'h00, 3'd0, 0, 0);
        add(1, 8'h00, 8'h00, 3'd0, 0, 0);
        add(1, 8'h00, 8'h00, 3'd0, 0, 0);
        add(1, 8'h00, 8'h00, 3'd0, 0, 0);
        add(1, 8'h10, 8'h10, 3'd4, 1, 1);
        add(1, 8'h10, 8'h10, 3'd4, 1, 0);
        add(1, 8'h00, 8'h00, 3'd4, 0, 0);
        add(1, 8'h00, 8'h00, 3'd4, 0, 0);
        add(0, 8'h00, 8'h00, 3'd0, 0, 0);
        add(1, 8'hFF, 8'h01, 3'd0, 1, 1);
        add(1, 8'hFE, 8'h02, 3'd1, 1, 1);
        add(1, 8'hFC, 8'h04, 3'd2, 1, 1);
        add(1, 8'hF8, 8'h08, 3'd3, 1, 1);
        add(1, 8'hF0, 8'h10, 3'd4, 1, 1);
        add(1, 8'hE0, 8'h20, 3'd5, 1, 1);
        add(1, 8'hC0, 8'h40, 3'd6, 1, 1);
        add(1, 8'h80, 8'h80, 3'd7, 1, 1);
        add(1, 8'h00, 8'h00, 3'd7, 0, 0);
        add(1, 8'h40, 8'h40, 3'd6, 1, 1);
        add(1, 8'h41, 8'h40, 3'd6, 1, 0);
        add(1, 8'h01, 8'h01, 3'd0, 1, 1);
        add(1, 8'h81, 8'h01, 3'd0, 1, 0);
        add(1, 8'h80, 8'h80, 3'd7, 1, 1);
        add(1, 8'h00, 8'h00, 3'd7, 0, 0);
        add(1, 8'h04, 8'h04, 3'd2, 1, 1);
        add(1, 8'h04, 8'h04, 3'd2, 1, 0);
        add(1, 8'h22, 8'h20, 3'd5, 1, 1);
        add(1, 8'h22, 8'h20, 3'd5, 1, 0);
        add(1, 8'h02, 8'h02, 3'd1, 1, 1);
        add(1, 8'h00, 8'h00, 3'd1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].rq);
            chk($sformatf("vec%0d_grant", i), 32'(grant),  32'(tbl[i].g));
            chk($sformatf("vec%0d_sel", i),   32'(sel),    32'(tbl[i].s));
            chk($sformatf("vec%0d_valid", i), 32'(valid),  32'(tbl[i].v));
            chk($sformatf("vec%0d_switch", i), 32'(switch), 32'(tbl[i].sw));
        end

        // Two requesters held constant: timeout alternates owners, otherwise owner 0 sticks.
        cyc(0, 8'h00);
        for (int k = 0; k < 20; k++) begin
            cyc(1, 8'h03);
            exp_o  = TIMEOUT ? (k / 4) % 2 : 0;
            exp_sw = TIMEOUT ? (k % 4 == 0) : (k == 0);
            exp_g  = 8'h01 << exp_o;
            chk($sformatf("hold%0d_grant", k), 32'(grant), 32'(exp_g));
            chk($sformatf("hold%0d_switch", k), 32'(switch), 32'(exp_sw));
        end
        // Lone owner is never preempted; counter stays saturated.
        for (int k = 0; k < 10; k++) begin
            cyc(1, 8'h01);
            chk($sformatf("lone%0d_grant", k), 32'(grant), 32'h01);
            chk($sformatf("lone%0d_switch", k), 32'(switch), 32'h0);
        end
        // A competitor arriving against a saturated counter takes over at once with timeout.
        cyc(1, 8'h03);
        chk("satpre_grant", 32'(grant), TIMEOUT ? 32'h02 : 32'h01);
        chk("satpre_switch", 32'(switch), TIMEOUT ? 32'h1 : 32'h0);

        // Randomized traffic against the model.
        cyc(0, 8'h00);
        r = 8'h00;
        for (int n = 0; n < 600; n++) begin
            logic rst;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            if (m_owner >= 0 && $urandom_range(0, 3) == 0) r[m_owner] = 1'b0;
            rst = ($urandom_range(0, 99) != 0);
            cyc(rst, r);
            exp_g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
            chk($sformatf("rnd%0d_grant", n),  32'(grant),  32'(exp_g));
            chk($sformatf("rnd%0d_sel", n),    32'(sel),    32'(m_sel));
            chk($sformatf("rnd%0d_valid", n),  32'(valid),  32'(m_owner >= 0));
            chk($sformatf("rnd%0d_switch", n), 32'(switch), 32'(m_sw));
            chk($sformatf("rnd%0d_onehot", n), 32'($onehot0(grant)), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
